// File: rtl/alarm_controller.sv
// Alarm stage behind the time-of-day counter: compares the current time with a stored alarm time
// and drives the buzzer through an IDLE / RINGING / SNOOZE machine with auto-timeout and bounded snoozes.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       alarm_enable,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic [1:0] alarm_state,
  output logic [2:0] snooze_count,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  localparam logic [8:0] RING_LOAD   = 9'(RING_SECONDS - 1);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECONDS - 1);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZES);

  state_t     state, state_nxt;
  logic [8:0] timer, timer_nxt;
  logic [2:0] count_nxt;
  logic       set_valid;
  logic       match;

  assign set_valid   = set_en && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
  // Compares against the registered alarm time, so a same-cycle set_en cannot trigger itself.
  assign match       = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);
  assign alarm_state = state;

  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      snooze_count  <= '0;
      buzzer        <= 1'b0;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      snooze_count <= count_nxt;
      buzzer       <= (state_nxt == RINGING);
      if (set_valid) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = snooze_count;
    if (!alarm_enable) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (set_valid) begin
      if (state != IDLE) begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state_nxt = RINGING;
            timer_nxt = RING_LOAD;
            count_nxt = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end else if (snooze && (snooze_count < SNOOZE_MAX)) begin
            state_nxt = SNOOZE;
            timer_nxt = SNOOZE_LOAD;
            count_nxt = snooze_count + 3'd1;
          end else if (timer == 9'd0) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - 9'd1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end else if (timer == 9'd0) begin
            state_nxt = RINGING;
            timer_nxt = RING_LOAD;
          end else begin
            timer_nxt = timer - 9'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: expected output bundles are queued when stimulus is driven
// and popped/compared after the sampling edge.
module tb_alarm_controller;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RING = 2'b01;
  localparam logic [1:0] S_SNZ  = 2'b10;

  logic       Clk_1sec = 1'b0;
  logic       reset;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       set_en;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       alarm_enable;
  logic       snooze;
  logic       stop;
  logic       buzzer;
  logic [1:0] alarm_state;
  logic [2:0] snooze_count;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  alarm_controller dut (
    .Clk_1sec      (Clk_1sec),
    .reset         (reset),
    .seconds       (seconds),
    .minutes       (minutes),
    .hours         (hours),
    .set_en        (set_en),
    .set_hours     (set_hours),
    .set_minutes   (set_minutes),
    .alarm_enable  (alarm_enable),
    .snooze        (snooze),
    .stop          (stop),
    .buzzer        (buzzer),
    .alarm_state   (alarm_state),
    .snooze_count  (snooze_count),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes)
  );

  always #5 Clk_1sec = ~Clk_1sec;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   th, tm, ts;
  int   eh, em;

  task automatic drive_time();
    hours   = 5'(th);
    minutes = 6'(tm);
    seconds = 6'(ts);
  endtask

  task automatic adv();
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) th = 0;
    drive_time();
  endtask

  task automatic push(input string tag, input logic b, input logic [1:0] st, input logic [2:0] c);
    exp_t e;
    e.tag = tag;
    e.v   = {b, st, c, 5'(eh), 6'(em)};
    q.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [16:0] obs;
    obs = {buzzer, alarm_state, snooze_count, alarm_hours, alarm_minutes};
    n_checks++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h required=queued_entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) n_pass++;
      else $error("FAIL %s observed={bz,st,cnt,h,m}=%h required=%h", e.tag, obs, e.v);
    end
  endtask

  // One clock: queue the expectation, let the edge sample, compare, advance time, drop pulses.
  task automatic step(input string tag, input logic b, input logic [1:0] st, input logic [2:0] c);
    push(tag, b, st, c);
    @(posedge Clk_1sec);
    #1;
    check_now();
    adv();
    set_en = 1'b0;
    snooze = 1'b0;
    stop   = 1'b0;
  endtask

  task automatic snooze_period(input logic [2:0] c);
    for (int i = 1; i < 300; i++) step("snz_quiet", 1'b0, S_SNZ, c);
    step("snz_resume", 1'b1, S_RING, c);
  endtask

  // Program the alarm for the next minute, idle up to it, and take the trigger edge.
  task automatic arm_next();
    int nh, nm, guard;
    nh = th;
    nm = tm + 1;
    if (nm == 60) begin nm = 0; nh = (th + 1) % 24; end
    set_en = 1'b1; set_hours = 5'(nh); set_minutes = 6'(nm);
    eh = nh; em = nm;
    step("arm", 1'b0, S_IDLE, 3'd0);
    guard = 0;
    while (!(th == eh && tm == em && ts == 0) && guard < 200) begin
      step("arm_wait", 1'b0, S_IDLE, 3'd0);
      guard++;
    end
    step("arm_trig", 1'b1, S_RING, 3'd0);
  endtask

  initial begin
    reset = 1'b1; set_en = 1'b0; set_hours = '0; set_minutes = '0;
    alarm_enable = 1'b0; snooze = 1'b0; stop = 1'b0;
    th = 7; tm = 29; ts = 58; eh = 0; em = 0;
    drive_time();
    #2;
    push("reset_state", 1'b0, S_IDLE, 3'd0);
    check_now();
    #10;
    reset = 1'b0;

    // Basic ring with auto-timeout after exactly 60 buzzer cycles.
    alarm_enable = 1'b1;
    set_en = 1'b1; set_hours = 5'd7; set_minutes = 6'd30;
    eh = 7; em = 30;
    step("set_0730", 1'b0, S_IDLE, 3'd0);
    step("pre_trigger", 1'b0, S_IDLE, 3'd0);
    step("trigger", 1'b1, S_RING, 3'd0);
    for (int i = 2; i <= 60; i++) step("ringing", 1'b1, S_RING, 3'd0);
    step("auto_timeout", 1'b0, S_IDLE, 3'd0);
    step("idle_after_timeout", 1'b0, S_IDLE, 3'd0);

    // Snooze at ring cycle 5, three snoozes, fourth ignored, then stop.
    arm_next();
    for (int i = 2; i <= 4; i++) step("ring_pre_snz", 1'b1, S_RING, 3'd0);
    snooze = 1'b1;
    step("snooze1", 1'b0, S_SNZ, 3'd1);
    snooze_period(3'd1);
    snooze = 1'b1;
    step("snooze2", 1'b0, S_SNZ, 3'd2);
    snooze_period(3'd2);
    snooze = 1'b1;
    step("snooze3", 1'b0, S_SNZ, 3'd3);
    snooze_period(3'd3);
    snooze = 1'b1;
    step("snooze4_ignored", 1'b1, S_RING, 3'd3);
    step("ring_after_ignored", 1'b1, S_RING, 3'd3);
    snooze = 1'b1;
    step("snz_in_snooze_ign_ring", 1'b1, S_RING, 3'd3);
    stop = 1'b1;
    step("stop_clears", 1'b0, S_IDLE, 3'd0);

    // stop and snooze together, then no re-trigger for the rest of the alarm minute.
    arm_next();
    stop = 1'b1; snooze = 1'b1;
    step("stop_beats_snooze", 1'b0, S_IDLE, 3'd0);
    while (ts != 0) step("no_retrigger", 1'b0, S_IDLE, 3'd0);
    step("next_minute_idle", 1'b0, S_IDLE, 3'd0);

    // alarm_enable drop during SNOOZE; snooze request while snoozing is ignored.
    arm_next();
    snooze = 1'b1;
    step("snooze_a", 1'b0, S_SNZ, 3'd1);
    snooze = 1'b1;
    step("snooze_in_snooze", 1'b0, S_SNZ, 3'd1);
    alarm_enable = 1'b0;
    step("disable_forces_idle", 1'b0, S_IDLE, 3'd0);
    alarm_enable = 1'b1;
    step("reenable_idle", 1'b0, S_IDLE, 3'd0);

    // Out-of-range sets are ignored; a valid set during SNOOZE loads and forces IDLE.
    set_en = 1'b1; set_hours = 5'd24; set_minutes = 6'd10;
    step("bad_hours", 1'b0, S_IDLE, 3'd0);
    set_en = 1'b1; set_hours = 5'd5; set_minutes = 6'd60;
    step("bad_minutes", 1'b0, S_IDLE, 3'd0);
    arm_next();
    set_en = 1'b1; set_hours = 5'd31; set_minutes = 6'd0;
    step("bad_set_in_ring", 1'b1, S_RING, 3'd0);
    snooze = 1'b1;
    step("snooze_b", 1'b0, S_SNZ, 3'd1);
    set_en = 1'b1; set_hours = 5'd12; set_minutes = 6'd34;
    eh = 12; em = 34;
    step("valid_set_in_snooze", 1'b0, S_IDLE, 3'd0);

    // Asynchronous reset mid-snooze, then a 00:00 alarm rings.
    arm_next();
    snooze = 1'b1;
    step("snooze_c", 1'b0, S_SNZ, 3'd1);
    #2;
    reset = 1'b1;
    #1;
    eh = 0; em = 0;
    push("async_reset", 1'b0, S_IDLE, 3'd0);
    check_now();
    #2;
    reset = 1'b0;
    th = 23; tm = 59; ts = 59;
    drive_time();
    step("pre_midnight", 1'b0, S_IDLE, 3'd0);
    step("midnight_trigger", 1'b1, S_RING, 3'd0);
    stop = 1'b1;
    step("midnight_stop", 1'b0, S_IDLE, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
